pattern_job_sched: RTL and testbench

//  Upstream job scheduler for the pattern_ad9748 pulse/PAT generator. Queues pulse-train jobs
//  (duty, gap, count, PAT) in a small FIFO and launches them one at a time.

---
 rtl/pattern_job_sched.sv | 211 +++++++++++++++++++++
 tb/tb_pattern_job_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_job_sched.sv
// Job FIFO and launch sequencer feeding the pattern_ad9748 pulse/PAT generator.
// Optional `PATSCHED_PREEMPT_EN: a queued job ends a running infinite job.
module pattern_job_sched #(
  parameter int unsigned _PAT_WIDTH    = 8,
  parameter int unsigned FIFO_AW       = 2,
  parameter int unsigned GAP_CYCLES    = 2,
  parameter int unsigned START_TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [7:0]             wr_duty,
  input  logic [15:0]            wr_dessert,
  input  logic [7:0]             wr_num,
  input  logic [_PAT_WIDTH-1:0]  wr_pat,
  input  logic                   flush,
  input  logic                   stop_req,
  input  logic                   clr_err,
  input  logic                   gen_busy,
  input  logic                   gen_valid,
  output logic                   pwm_en,
  output logic [7:0]             duty_num,
  output logic [15:0]            pulse_dessert,
  output logic [7:0]             pulse_num,
  output logic [_PAT_WIDTH-1:0]  PAT,
  output logic                   fifo_full,
  output logic [FIFO_AW:0]       fifo_level,
  output logic                   sched_busy,
  output logic                   job_done,
  output logic [15:0]            jobs_done,
  output logic                   err_ovf,
  output logic                   err_timeout
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;
  localparam int unsigned JOB_W = 32 + _PAT_WIDTH;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_RUN    = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;

  logic [JOB_W-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]      level_q, level_d;
  logic [2:0]            state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic                  pwm_en_q, pwm_en_d;
  logic [7:0]            duty_q, duty_d, num_q, num_d;
  logic [15:0]           dessert_q, dessert_d;
  logic [_PAT_WIDTH-1:0] pat_q, pat_d;
  logic                  job_done_q, job_done_d;
  logic [15:0]           jobs_done_q, jobs_done_d;
  logic                  err_ovf_q, err_ovf_d, err_timeout_q, err_timeout_d;

  logic             full, push, pop, drop, stop_ev, to_last, gap_last;
  logic [JOB_W-1:0] head;

  assign full     = (level_q == (FIFO_AW+1)'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign push     = wr_en && !flush && !full;
  assign drop     = wr_en && !flush && full;
  assign pop      = (state_q == S_IDLE) && (level_q != '0) && !gen_busy && !flush;
  assign to_last  = (32'(cnt_q) + 32'd1) >= START_TIMEOUT;
  assign gap_last = (32'(cnt_q) + 32'd1) >= GAP_CYCLES;

`ifdef PATSCHED_PREEMPT_EN
  assign stop_ev = stop_req || (level_q != '0);
`else
  assign stop_ev = stop_req;
`endif

  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    pwm_en_d      = pwm_en_q;
    duty_d        = duty_q;
    dessert_d     = dessert_q;
    num_d         = num_q;
    pat_d         = pat_q;
    job_done_d    = 1'b0;
    jobs_done_d   = jobs_done_q;
    err_ovf_d     = err_ovf_q;
    err_timeout_d = err_timeout_q;

    if (flush) begin
      level_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
      if (push && !pop)      level_d = level_q + (FIFO_AW+1)'(1);
      else if (!push && pop) level_d = level_q - (FIFO_AW+1)'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {duty_d, dessert_d, num_d, pat_d} = head;
          pwm_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (gen_busy) begin
          // finite jobs drop pwm_en at once so the generator cannot re-trigger
          pwm_en_d = (num_q == 8'd0);
          state_d  = S_RUN;
        end else if (to_last) begin
          err_timeout_d = 1'b1;
          pwm_en_d      = 1'b0;
          job_done_d    = 1'b1;
          cnt_d         = '0;
          state_d       = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RUN: begin
        if (num_q != 8'd0) begin
          if (!gen_busy) begin
            job_done_d  = 1'b1;
            jobs_done_d = jobs_done_q + 16'd1;
            cnt_d       = '0;
            state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end
        end else if (stop_ev) begin
          pwm_en_d = 1'b0;
          state_d  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (!gen_busy) begin
          job_done_d  = 1'b1;
          jobs_done_d = jobs_done_q + 16'd1;
          cnt_d       = '0;
          state_d     = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
        end
      end
      S_GAP: begin
        if (gap_last) state_d = S_IDLE;
        else          cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_IDLE;
    endcase

    if (drop)         err_ovf_d = 1'b1;
    else if (clr_err) err_ovf_d = 1'b0;
    if (clr_err && !(state_q == S_LAUNCH && !gen_busy && to_last)) err_timeout_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {wr_duty, wr_dessert, wr_num, wr_pat};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      pwm_en_q      <= 1'b0;
      duty_q        <= '0;
      dessert_q     <= '0;
      num_q         <= '0;
      pat_q         <= '0;
      job_done_q    <= 1'b0;
      jobs_done_q   <= '0;
      err_ovf_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      level_q       <= level_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pwm_en_q      <= pwm_en_d;
      duty_q        <= duty_d;
      dessert_q     <= dessert_d;
      num_q         <= num_d;
      pat_q         <= pat_d;
      job_done_q    <= job_done_d;
      jobs_done_q   <= jobs_done_d;
      err_ovf_q     <= err_ovf_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign pwm_en        = pwm_en_q;
  assign duty_num      = duty_q;
  assign pulse_dessert = dessert_q;
  assign pulse_num     = num_q;
  assign PAT           = pat_q;
  assign fifo_full     = full;
  assign fifo_level    = level_q;
  assign sched_busy    = (state_q != S_IDLE);
  assign job_done      = job_done_q;
  assign jobs_done     = jobs_done_q;
  assign err_ovf       = err_ovf_q;
  assign err_timeout   = err_timeout_q;

  logic unused_ok;
  assign unused_ok = gen_valid;

endmodule

// File: tb/tb_pattern_job_sched.sv
// Directed bench for pattern_job_sched with a small behavioural generator attached.
module tb_pattern_job_sched;
  logic        clk = 1'b0;
  logic        rst_n, wr_en, flush, stop_req, clr_err, gen_busy, gen_valid;
  logic [7:0]  wr_duty, wr_num, wr_pat;
  logic [15:0] wr_dessert;
  logic        pwm_en, fifo_full, sched_busy, job_done, err_ovf, err_timeout;
  logic [7:0]  duty_num, pulse_num, PAT;
  logic [15:0] pulse_dessert, jobs_done;
  logic [2:0]  fifo_level;

  int checks = 0, errors = 0, rise_cnt = 0, done_cnt = 0, exp_jobs = 0;
  bit gen_hold = 0, gen_dead = 0;
  logic pwm_prev = 1'b0;

  pattern_job_sched #(._PAT_WIDTH(8), .FIFO_AW(2), .GAP_CYCLES(2), .START_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_duty(wr_duty), .wr_dessert(wr_dessert),
    .wr_num(wr_num), .wr_pat(wr_pat), .flush(flush), .stop_req(stop_req), .clr_err(clr_err),
    .gen_busy(gen_busy), .gen_valid(gen_valid), .pwm_en(pwm_en), .duty_num(duty_num),
    .pulse_dessert(pulse_dessert), .pulse_num(pulse_num), .PAT(PAT), .fifo_full(fifo_full),
    .fifo_level(fifo_level), .sched_busy(sched_busy), .job_done(job_done),
    .jobs_done(jobs_done), .err_ovf(err_ovf), .err_timeout(err_timeout));

  always #5 clk = ~clk;

  // generator: finite jobs busy for 10 cycles, infinite jobs until 2 cycles after pwm_en falls
  initial begin
    int rem;
    rem = 0; gen_busy = 1'b0; gen_valid = 1'b0;
    forever begin
      @(negedge clk);
      gen_valid = 1'b0;
      if (!rst_n || gen_dead) begin gen_busy = 1'b0; rem = 0; end
      else if (gen_hold) gen_busy = 1'b1;
      else if (!gen_busy) begin
        if (pwm_en) begin gen_busy = 1'b1; rem = (pulse_num == 8'd0) ? 2 : 10; end
      end else if (pulse_num != 8'd0 || !pwm_en) begin
        if (rem <= 1) begin gen_busy = 1'b0; gen_valid = 1'b1; end
        else rem = rem - 1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (job_done === 1'b1) done_cnt++;
      if (pwm_en === 1'b1 && pwm_prev === 1'b0) rise_cnt++;
      pwm_prev = pwm_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic push(input logic [7:0] d, input logic [15:0] ds, input logic [7:0] n,
                      input logic [7:0] p);
    wr_en = 1'b1; wr_duty = d; wr_dessert = ds; wr_num = n; wr_pat = p;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_pwm(input logic v, input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (pwm_en === v) begin ok = 1; break; end
    end
  endtask

  task automatic wait_idle(input int max, output bit ok);
    ok = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (sched_busy === 1'b0 && fifo_level === 3'd0) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({pwm_en, duty_num, pulse_dessert, pulse_num, PAT} !== 41'd0) begin
      errors++; $display("FAIL reset_cfg got %h want 0", {pwm_en, duty_num, pulse_dessert, pulse_num, PAT});
    end
    checks++;
    if ({fifo_full, fifo_level, sched_busy, job_done} !== 6'd0) begin
      errors++; $display("FAIL reset_status got %b want 0", {fifo_full, fifo_level, sched_busy, job_done});
    end
    checks++;
    if ({jobs_done, err_ovf, err_timeout} !== 18'd0) begin
      errors++; $display("FAIL reset_counters got %h want 0", {jobs_done, err_ovf, err_timeout});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_job;
    int r0, d0;
    bit ok;
    r0 = rise_cnt; d0 = done_cnt;
    push(8'd3, 16'd5, 8'd2, 8'b0000_0101);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (gen_busy) begin
        checks++;
        if ({duty_num, pulse_dessert, pulse_num, PAT} !== {8'd3, 16'd5, 8'd2, 8'h05}) begin
          errors++; $display("FAIL single_cfg_stable got %h want 03000502_05", {duty_num, pulse_dessert, pulse_num, PAT});
        end
      end
      if (!sched_busy && fifo_level == 3'd0) begin ok = 1; break; end
    end
    exp_jobs++;
    checks++; if (!ok) begin errors++; $display("FAIL single_idle got timeout want idle"); end
    checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL single_rises got %0d want 1", rise_cnt - r0); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done got %0d want 1", done_cnt - d0); end
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL single_jobs got %0d want %0d", jobs_done, exp_jobs); end
  endtask

  task automatic test_overflow;
    gen_hold = 1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) push(8'(i), 16'(i), 8'd1, 8'(i));
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", fifo_level); end
    checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", fifo_full); end
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", err_ovf); end
    checks++; if (sched_busy !== 1'b0) begin errors++; $display("FAIL ovf_nopop got %b want 0", sched_busy); end
    clr_err = 1'b1;
    push(8'd9, 16'd9, 8'd9, 8'd9);
    clr_err = 1'b0;
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", err_ovf); end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", err_ovf); end
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL ovf_clr_level got %0d want 4", fifo_level); end
    flush = 1'b1; @(negedge clk); flush = 1'b0;
    checks++; if ({fifo_level, fifo_full} !== 4'd0) begin errors++; $display("FAIL ovf_flush got %b want 0", {fifo_level, fifo_full}); end
    gen_hold = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_infinite_stop;
    bit ok;
    int hi, n;
    push(8'd1, 16'd1, 8'd0, 8'h11);
    wait_pwm(1'b1, 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL inf_start got timeout want pwm_en"); end
    hi = 0;
    repeat (100) begin @(negedge clk); if (pwm_en === 1'b1) hi++; end
    checks++; if (hi != 100) begin errors++; $display("FAIL inf_hold got %0d want 100", hi); end
    stop_req = 1'b1;
    push(8'd4, 16'd4, 8'd1, 8'h22);
    stop_req = 1'b0;
    checks++; if (pwm_en !== 1'b0) begin errors++; $display("FAIL inf_stop got %b want 0", pwm_en); end
    ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (job_done === 1'b1) begin ok = 1; break; end
    end
    exp_jobs++;
    checks++; if (!ok) begin errors++; $display("FAIL inf_done got timeout want job_done"); end
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); n++;
      if (pwm_en === 1'b1) break;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL inf_gap got %0d want 3", n); end
    checks++; if ({duty_num, PAT} !== {8'd4, 8'h22}) begin errors++; $display("FAIL inf_next_cfg got %h want 0422", {duty_num, PAT}); end
    wait_idle(100, ok);
    exp_jobs++;
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL inf_jobs got %0d want %0d", jobs_done, exp_jobs); end
  endtask

  task automatic test_timeout;
    bit ok;
    int n;
    gen_dead = 1;
    @(negedge clk);
    push(8'd2, 16'd2, 8'd3, 8'h33);
    wait_pwm(1'b1, 50, ok);
    n = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (pwm_en === 1'b1) n++; else break;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL to_len got %0d want 16", n); end
    checks++; if (err_timeout !== 1'b1) begin errors++; $display("FAIL to_flag got %b want 1", err_timeout); end
    checks++; if (job_done !== 1'b1) begin errors++; $display("FAIL to_done got %b want 1", job_done); end
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL to_jobs got %0d want %0d", jobs_done, exp_jobs); end
    gen_dead = 0;
    push(8'd5, 16'd6, 8'd7, 8'h44);
    wait_pwm(1'b1, 50, ok);
    checks++; if ({duty_num, pulse_dessert, pulse_num, PAT} !== {8'd5, 16'd6, 8'd7, 8'h44}) begin
      errors++; $display("FAIL to_next_cfg got %h want 05000607_44", {duty_num, pulse_dessert, pulse_num, PAT});
    end
    wait_idle(100, ok);
    exp_jobs++;
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL to_next_jobs got %0d want %0d", jobs_done, exp_jobs); end
    clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
    checks++; if (err_timeout !== 1'b0) begin errors++; $display("FAIL to_clr got %b want 0", err_timeout); end
  endtask

  task automatic test_flush;
    bit ok;
    int r0, d0;
    r0 = rise_cnt; d0 = done_cnt;
    push(8'd1, 16'd2, 8'd3, 8'h55);
    wait_pwm(1'b1, 50, ok);
    for (int i = 0; i < 4; i++) push(8'd9, 16'd9, 8'd9, 8'(i));
    checks++; if (fifo_level !== 3'd4) begin errors++; $display("FAIL fl_pre_level got %0d want 4", fifo_level); end
    flush = 1'b1;
    push(8'd7, 16'd7, 8'd7, 8'd7);
    flush = 1'b0;
    checks++; if (fifo_level !== 3'd0) begin errors++; $display("FAIL fl_level got %0d want 0", fifo_level); end
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL fl_ovf got %b want 0", err_ovf); end
    checks++; if (sched_busy !== 1'b1) begin errors++; $display("FAIL fl_running got %b want 1", sched_busy); end
    wait_idle(100, ok);
    exp_jobs++;
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL fl_jobs got %0d want %0d", jobs_done, exp_jobs); end
    checks++; if (rise_cnt - r0 != 1 || done_cnt - d0 != 1) begin
      errors++; $display("FAIL fl_counts got rises %0d dones %0d want 1 1", rise_cnt - r0, done_cnt - d0);
    end
  endtask

  task automatic test_preempt;
    bit ok;
    int hi;
    push(8'd7, 16'd7, 8'd0, 8'h66);
    wait_pwm(1'b1, 50, ok);
    repeat (5) @(negedge clk);
    push(8'd8, 16'd9, 8'd1, 8'h77);
`ifdef PATSCHED_PREEMPT_EN
    @(negedge clk);
    checks++; if (pwm_en !== 1'b0) begin errors++; $display("FAIL pre_drop got %b want 0", pwm_en); end
`else
    hi = 0;
    repeat (20) begin @(negedge clk); if (pwm_en === 1'b1) hi++; end
    checks++; if (hi != 20) begin errors++; $display("FAIL pre_hold got %0d want 20", hi); end
    checks++; if ({fifo_level, pulse_num} !== {3'd1, 8'd0}) begin errors++; $display("FAIL pre_queued got %h want 100", {fifo_level, pulse_num}); end
    stop_req = 1'b1; @(negedge clk); stop_req = 1'b0;
`endif
    wait_pwm(1'b1, 50, ok);
    checks++; if ({duty_num, pulse_dessert, pulse_num, PAT} !== {8'd8, 16'd9, 8'd1, 8'h77}) begin
      errors++; $display("FAIL pre_next_cfg got %h want 08000901_77", {duty_num, pulse_dessert, pulse_num, PAT});
    end
    wait_idle(100, ok);
    exp_jobs += 2;
    checks++; if (jobs_done !== 16'(exp_jobs)) begin errors++; $display("FAIL pre_jobs got %0d want %0d", jobs_done, exp_jobs); end
  endtask

  task automatic test_reset_midjob;
    bit ok;
    push(8'd1, 16'd1, 8'd0, 8'h01);
    wait_pwm(1'b1, 50, ok);
    push(8'd2, 16'd2, 8'd0, 8'h02);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pwm_en, fifo_level, sched_busy, jobs_done, duty_num, PAT} !== 37'd0) begin
      errors++; $display("FAIL midreset got %h want 0", {pwm_en, fifo_level, sched_busy, jobs_done, duty_num, PAT});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    wr_en = 0; flush = 0; stop_req = 0; clr_err = 0;
    wr_duty = '0; wr_dessert = '0; wr_num = '0; wr_pat = '0;
    rst_n = 1'b0;
    test_reset;
    test_single_job;
    test_overflow;
    test_infinite_stop;
    test_timeout;
    test_flush;
    test_preempt;
    test_reset_midjob;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
